// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: frame-tick game-flow sequencer (countdown, staged attacker release, lives, survival timer, end screen)
module game_seq_ctrl #(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned COUNT_FROM     = 3,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned HIT_FRAMES     = 90,
    parameter int unsigned RELEASE_FRAMES = 120,
    parameter int unsigned SURVIVE_SEC    = 60
) (
    input  logic       clk_65M,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic [5:0] atk_over,
    output logic [2:0] state,
    output logic       game_stop,
    output logic [5:0] atk_en,
    output logic [3:0] count_digit,
    output logic [1:0] lives,
    output logic [7:0] time_left,
    output logic       show_thumbup,
    output logic       show_thumbdown
);
    typedef enum logic [2:0] {IDLE = 3'd0, COUNTDOWN = 3'd1, PLAY = 3'd2, HIT = 3'd3, WIN = 3'd4, LOSE = 3'd5} state_e;
    localparam logic [15:0] SEC_LAST = 16'(FRAMES_PER_SEC - 1);
    localparam logic [15:0] HIT_LAST = 16'(HIT_FRAMES - 1);
    localparam logic [15:0] REL_LAST = 16'(RELEASE_FRAMES - 1);
    localparam logic [3:0]  DIGIT0   = 4'(COUNT_FROM);
    localparam logic [1:0]  LIVES0   = 2'(LIVES);
    localparam logic [7:0]  TIME0    = 8'(SURVIVE_SEC);
    state_e      state_q, state_d;
    logic [15:0] frame_cnt_q, frame_cnt_d, rel_cnt_q, rel_cnt_d;
    logic [2:0]  rel_idx_q, rel_idx_d;
    logic [5:0]  atk_en_q, atk_en_d;
    logic [3:0]  digit_q, digit_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  time_q, time_d;
    logic        go_idle;
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        rel_idx_d   = rel_idx_q;
        atk_en_d    = atk_en_q;
        digit_d     = digit_q;
        lives_d     = lives_q;
        time_d      = time_q;
        go_idle     = 1'b0;
        case (state_q)
            IDLE: begin
                go_idle = !game_start;
                if (game_start) begin
                    state_d     = COUNTDOWN;
                    digit_d     = DIGIT0;
                    frame_cnt_d = '0;
                    time_d      = TIME0;
                end
            end
            COUNTDOWN: begin
                if (frame_tick) begin
                    frame_cnt_d = (frame_cnt_q == SEC_LAST) ? '0 : frame_cnt_q + 16'd1;
                    if (frame_cnt_q == SEC_LAST) begin
                        digit_d = (digit_q > 4'd1) ? digit_q - 4'd1 : 4'd0;
                        if (digit_q <= 4'd1) begin
                            state_d   = PLAY;
                            atk_en_d  = 6'b000001;
                            rel_idx_d = 3'd1;
                            rel_cnt_d = '0;
                        end
                    end
                end
            end
            PLAY: begin
                // A hit pre-empts both the release and the timer expiry in the same cycle
                if (|atk_over) begin
                    state_d     = HIT;
                    lives_d     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    atk_en_d    = '0;
                    frame_cnt_d = '0;
                end else if (frame_tick) begin
                    rel_cnt_d = (rel_cnt_q == REL_LAST) ? '0 : rel_cnt_q + 16'd1;
                    if (rel_cnt_q == REL_LAST && rel_idx_q < 3'd6) begin
                        atk_en_d  = atk_en_q | (6'b000001 << rel_idx_q);
                        rel_idx_d = rel_idx_q + 3'd1;
                    end
                    frame_cnt_d = (frame_cnt_q == SEC_LAST) ? '0 : frame_cnt_q + 16'd1;
                    if (frame_cnt_q == SEC_LAST) begin
                        time_d  = (time_q != 8'd0) ? time_q - 8'd1 : 8'd0;
                        state_d = (time_q <= 8'd1) ? WIN : PLAY;
                    end
                end
            end
            HIT: begin
                if (frame_tick) begin
                    frame_cnt_d = (frame_cnt_q == HIT_LAST) ? '0 : frame_cnt_q + 16'd1;
                    if (frame_cnt_q == HIT_LAST) begin
                        state_d = (lives_q == 2'd0) ? LOSE : COUNTDOWN;
                        digit_d = (lives_q == 2'd0) ? digit_q : DIGIT0;
                    end
                end
            end
            WIN, LOSE: go_idle = game_start;
            default:   go_idle = 1'b1;
        endcase
        if (go_idle) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
            rel_cnt_d   = '0;
            rel_idx_d   = '0;
            atk_en_d    = '0;
            digit_d     = '0;
            lives_d     = LIVES0;
            time_d      = TIME0;
        end
    end
    always_ff @(posedge clk_65M) begin
        if (clear) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            rel_cnt_q   <= '0;
            rel_idx_q   <= '0;
            atk_en_q    <= '0;
            digit_q     <= '0;
            lives_q     <= LIVES0;
            time_q      <= TIME0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            rel_idx_q   <= rel_idx_d;
            atk_en_q    <= atk_en_d;
            digit_q     <= digit_d;
            lives_q     <= lives_d;
            time_q      <= time_d;
        end
    end
    assign state          = state_q;
    assign game_stop      = (state_q != PLAY);
    assign atk_en         = atk_en_q;
    assign count_digit    = digit_q;
    assign lives          = lives_q;
    assign time_left      = time_q;
    assign show_thumbup   = (state_q == WIN);
    assign show_thumbdown = (state_q == LOSE);
endmodule
